seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply.
// Define SEQ_ALU_MUL_EN to build the MUL path (BUSY state, counter, multiplier datapath).
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a request transfers on an edge with in_valid && in_ready; a result
    // transfers on an edge with out_valid && out_ready. Neither valid depends on its ready.
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_LT  = 4'b0111;
    localparam logic [3:0] OP_LSR = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_ASR = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef SEQ_ALU_MUL_EN
        BUSY = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             is_mul;

`ifdef SEQ_ALU_MUL_EN
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_next;

    assign is_mul   = (alu_op == OP_MUL);
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign is_mul   = 1'b0;
`endif

    assign shamt = op2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_ADD:  alu_res = op1 + op2;
            OP_SUB:  alu_res = op1 - op2;
            OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_LSR:  alu_res = op1 >> shamt;
            OP_LSL:  alu_res = op1 << shamt;
            OP_ASR:  alu_res = $signed(op1) >>> shamt;
            OP_XOR:  alu_res = op1 ^ op2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef SEQ_ALU_MUL_EN
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_mul) begin
`ifdef SEQ_ALU_MUL_EN
                        state_d  = BUSY;
                        cnt_d    = '0;
                        mcand_d  = op1;
                        mplier_d = op2;
                        acc_d    = '0;
`endif
                    end else begin
                        state_d  = DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                    end
                end
            end
`ifdef SEQ_ALU_MUL_EN
            // One multiplier bit per cycle: multiplicand walks left, multiplier walks right.
            BUSY: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = acc_next;
                    zero_d   = (acc_next == '0);
                    cnt_d    = '0;
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
`ifdef SEQ_ALU_MUL_EN
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef SEQ_ALU_MUL_EN
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = result_q;
    assign zero        = zero_q;
    assign dbg_state_o = state_q;

endmodule
